// File: rtl/rf_write_arbiter_pkg.sv
// Register-file constants shared by the writeback arbiter and its clients.
package rf_write_arbiter_pkg;

    localparam int unsigned RF_ADDR_W = 6;
    localparam int unsigned RF_DATA_W = 32;

    localparam logic [RF_ADDR_W-1:0] RF_REG_ZERO = 6'h00;
    localparam logic [RF_ADDR_W-1:0] RF_REG_HI   = 6'h20;
    localparam logic [RF_ADDR_W-1:0] RF_REG_LO   = 6'h21;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback requester bundle plus the register-file write port it feeds.
interface rf_write_arbiter_if
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = RF_ADDR_W,
    parameter int unsigned DATA_W  = RF_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_pair;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*ADDR_W-1:0] req_addr2;
    logic [NUM_REQ*DATA_W-1:0] req_data2;

    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_waddr;
    logic [DATA_W-1:0]         rf_wdata;
    logic                      busy;

    modport master (
        output req_valid, req_pair, req_addr, req_data, req_addr2, req_data2,
        input  req_ready, rf_we, rf_waddr, rf_wdata, busy
    );

    modport slave (
        input  req_valid, req_pair, req_addr, req_data, req_addr2, req_data2,
        output req_ready, rf_we, rf_waddr, rf_wdata, busy
    );

endinterface

// File: rtl/rf_write_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int unsigned PTR_W = $clog2(N);

    logic [PTR_W-1:0] cand;

    // N is a power of two, so PTR_W-bit addition wraps modulo N for free.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < int'(N); i++) begin
            cand = PTR_W'(ptr + PTR_W'(i));
            if (!gnt_valid && req[cand]) begin
                gnt_valid  = 1'b1;
                gnt[cand]  = 1'b1;
                gnt_idx    = cand;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single RF write port among writeback units; paired writes issue as two beats.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = RF_ADDR_W,
    parameter int unsigned DATA_W  = RF_DATA_W
) (
    input  logic clk,
    input  logic rst,
    rf_write_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PAIR = 1'b1
    } state_e;

    state_e             state;
    logic [PTR_W-1:0]   ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_valid;

    logic [ADDR_W-1:0]  addr1_arr [NUM_REQ];
    logic [DATA_W-1:0]  data1_arr [NUM_REQ];
    logic [ADDR_W-1:0]  addr2_arr [NUM_REQ];
    logic [DATA_W-1:0]  data2_arr [NUM_REQ];

    logic [ADDR_W-1:0]  addr2_q;
    logic [DATA_W-1:0]  data2_q;

    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
        assign addr1_arr[i] = bus.req_addr [i*ADDR_W +: ADDR_W];
        assign data1_arr[i] = bus.req_data [i*DATA_W +: DATA_W];
        assign addr2_arr[i] = bus.req_addr2[i*ADDR_W +: ADDR_W];
        assign data2_arr[i] = bus.req_data2[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign bus.req_ready = (state == ST_IDLE && !rst) ? gnt : '0;

    // Writes to $zero still consume their slot but drive the port as all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            addr2_q      <= '0;
            data2_q      <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        bus.rf_we    <= (addr1_arr[gnt_idx] != '0);
                        bus.rf_waddr <= addr1_arr[gnt_idx];
                        bus.rf_wdata <= (addr1_arr[gnt_idx] != '0) ? data1_arr[gnt_idx] : '0;
                        ptr          <= PTR_W'(gnt_idx + PTR_W'(1));
                        if (bus.req_pair[gnt_idx]) begin
                            addr2_q  <= addr2_arr[gnt_idx];
                            data2_q  <= data2_arr[gnt_idx];
                            state    <= ST_PAIR;
                            bus.busy <= 1'b1;
                        end
                    end else begin
                        bus.rf_we    <= 1'b0;
                        bus.rf_waddr <= '0;
                        bus.rf_wdata <= '0;
                    end
                end
                ST_PAIR: begin
                    bus.rf_we    <= (addr2_q != '0);
                    bus.rf_waddr <= addr2_q;
                    bus.rf_wdata <= (addr2_q != '0) ? data2_q : '0;
                    state        <= ST_IDLE;
                    bus.busy     <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
